// File: rtl/amp_gain_seq_pkg.sv
// Shared types and helpers for the amplifier power/gain sequencer.
package amp_gain_seq_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StWake     = 3'd1,
    StRamp     = 3'd2,
    StOn       = 3'd3,
    StRampDown = 3'd4
  } amp_state_e;

  // Counter width able to hold the larger of the two interval lengths.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/amp_gain_seq_if.sv
// Target-gain handshake between config logic (master) and the sequencer (slave).
interface amp_gain_seq_if #(
  parameter int unsigned NCH    = 1,
  parameter int unsigned GAIN_W = 2
);
  logic                    cfg_valid;
  logic [NCH*GAIN_W-1:0]   cfg_gain;
  logic                    cfg_ready;

  modport master (output cfg_valid, output cfg_gain, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_gain, output cfg_ready);
endinterface

// File: rtl/amp_gain_seq_timer.sv
// Loadable down-counter that parks at zero; expired_o flags the zero count.
module amp_gain_seq_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/amp_gain_sequencer.sv
// Shutdown release, settling delay and pop-free gain ramping for PmodAMP2-class amps.
// AMP_GAIN_SEQ_RAMP_EN: step gains one LSB per interval; undefined jumps straight to target/0.
module amp_gain_sequencer
  import amp_gain_seq_pkg::*;
#(
  parameter int unsigned NCH            = 1,
  parameter int unsigned GAIN_W         = 2,
  parameter int unsigned STARTUP_CYCLES = 100000,
  parameter int unsigned STEP_CYCLES    = 1000,
  parameter int unsigned DEFAULT_GAIN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  amp_gain_seq_if.slave         cfg,
  output logic [NCH*GAIN_W-1:0] gain,
  output logic                  sd_n,
  output logic                  busy,
  output logic [2:0]            state
);

  localparam int unsigned TimerW = timer_width(STARTUP_CYCLES, STEP_CYCLES);
  localparam logic [TimerW-1:0] StartLoad = TimerW'(STARTUP_CYCLES - 1);
  localparam logic [TimerW-1:0] StepLoad  = TimerW'(STEP_CYCLES - 1);
  localparam logic [NCH-1:0][GAIN_W-1:0] TgtRst = {NCH{GAIN_W'(DEFAULT_GAIN)}};

  amp_state_e                   state_q, state_d;
  logic [NCH-1:0][GAIN_W-1:0]   gain_q, gain_d;
  logic [NCH-1:0][GAIN_W-1:0]   tgt_q, tgt_d;
  logic                         sd_n_q, sd_n_d;
  logic                         cfg_ready;
  logic                         accept;
  logic                         tmr_load;
  logic [TimerW-1:0]            tmr_val;
  logic                         tmr_exp;

`ifdef AMP_GAIN_SEQ_RAMP_EN
  // Moves one LSB toward tgt and never passes it, so the code cannot wrap.
  function automatic logic [GAIN_W-1:0] step_toward(input logic [GAIN_W-1:0] cur,
                                                    input logic [GAIN_W-1:0] tgt);
    if (cur < tgt) return cur + GAIN_W'(1);
    if (cur > tgt) return cur - GAIN_W'(1);
    return cur;
  endfunction
`endif

  amp_gain_seq_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  assign cfg_ready     = (state_q == StOff) || (state_q == StOn);
  assign cfg.cfg_ready = cfg_ready;
  assign accept        = cfg.cfg_valid & cfg_ready;

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    tgt_d    = tgt_q;
    sd_n_d   = sd_n_q;
    tmr_load = 1'b0;
    tmr_val  = StepLoad;

    if (accept) tgt_d = cfg.cfg_gain;

    unique case (state_q)
      StOff: begin
        sd_n_d = 1'b0;
        gain_d = '0;
        if (enable) begin
          state_d  = StWake;
          sd_n_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = StartLoad;
        end
      end
      StWake: begin
        if (!enable) begin
          state_d = StOff;
          sd_n_d  = 1'b0;
        end else if (tmr_exp) begin
          state_d  = StRamp;
          tmr_load = 1'b1;
        end
      end
      StRamp: begin
        // Disable keeps the running interval; ramp-down continues from current gains.
        if (!enable) begin
          state_d = StRampDown;
        end else if (gain_q == tgt_q) begin
          state_d = StOn;
        end else begin
`ifdef AMP_GAIN_SEQ_RAMP_EN
          if (tmr_exp) begin
            for (int i = 0; i < NCH; i++) gain_d[i] = step_toward(gain_q[i], tgt_q[i]);
            tmr_load = 1'b1;
          end
`else
          gain_d = tgt_q;
`endif
        end
      end
      StOn: begin
        if (!enable) begin
          state_d  = StRampDown;
          tmr_load = 1'b1;
        end else if (accept && (tgt_d != gain_q)) begin
          state_d  = StRamp;
          tmr_load = 1'b1;
        end
      end
      StRampDown: begin
`ifdef AMP_GAIN_SEQ_RAMP_EN
        if (tmr_exp) begin
          for (int i = 0; i < NCH; i++) gain_d[i] = step_toward(gain_q[i], '0);
          tmr_load = 1'b1;
        end
`else
        gain_d = '0;
`endif
        // Shutdown lands on the same edge as the final zero gain.
        if (gain_d == '0) begin
          state_d = StOff;
          sd_n_d  = 1'b0;
        end
      end
      default: begin
        state_d = StOff;
        sd_n_d  = 1'b0;
        gain_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      gain_q  <= '0;
      tgt_q   <= TgtRst;
      sd_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      tgt_q   <= tgt_d;
      sd_n_q  <= sd_n_d;
    end
  end

  assign gain  = gain_q;
  assign sd_n  = sd_n_q;
  assign busy  = (state_q == StWake) || (state_q == StRamp) || (state_q == StRampDown);
  assign state = state_q;

endmodule
